// File: rtl/spi_master_gen.sv
// SPI master with SCK divider, N active-low selects and multi-word bursts.
// Optional loopback sampling (mosi_o instead of miso_i) under SPI_MASTER_GEN_LOOPBACK_EN.
module spi_master_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_SS   = 1,
  parameter int unsigned DIV_W  = 8,
  localparam int unsigned SS_W  = (N_SS > 1) ? $clog2(N_SS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              dord_i,
  input  logic [SS_W-1:0]   ss_sel_i,
  input  logic              start_i,
  input  logic              last_i,
  input  logic              end_i,
  input  logic [DATA_W-1:0] tx_i,
  output logic [DATA_W-1:0] rx_o,
  output logic              rx_valid_o,
  output logic              ready_o,
  output logic              busy_o,
  output logic              irq_o,
  input  logic              ack_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              mosi_en_o,
  input  logic              miso_i,
`ifdef SPI_MASTER_GEN_LOOPBACK_EN
  input  logic              loop_i,
`endif
  output logic [N_SS-1:0]   ss_n_o
);

  localparam int unsigned BW = $clog2(DATA_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_TRAIL = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DESEL = 3'd5;

  logic [2:0]        state, state_d;
  logic [DIV_W-1:0]  cnt, div_q;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] sr, sr_shift;
  logic [SS_W-1:0]   sel_q;
  logic              cpol_q, cpha_q, dord_q, last_q;
  logic              samp, sclk_r;
  logic              tick, accept, last_bit, smp_src;

  assign ready_o   = (state == S_IDLE) || (state == S_WAIT);
  assign busy_o    = (state != S_IDLE);
  assign mosi_en_o = busy_o && (state != S_DESEL);
  assign accept    = start_i && ready_o;
  assign tick      = (cnt == div_q);
  assign last_bit  = (bit_cnt == BW'(DATA_W - 1));
  assign sclk_o    = sclk_r ^ (busy_o ? cpol_q : cpol_i);
  assign mosi_o    = mosi_en_o & (dord_q ? sr[0] : sr[DATA_W-1]);
  assign sr_shift  = dord_q ? {samp, sr[DATA_W-1:1]} : {sr[DATA_W-2:0], samp};

`ifdef SPI_MASTER_GEN_LOOPBACK_EN
  assign smp_src = loop_i ? mosi_o : miso_i;
`else
  assign smp_src = miso_i;
`endif

  // Selected slave is held low from LEAD through WAIT_NEXT; out-of-range index selects none.
  always_comb begin
    ss_n_o = '1;
    for (int unsigned i = 0; i < N_SS; i++) begin
      if (mosi_en_o && (sel_q == SS_W'(i))) ss_n_o[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start_i) state_d = S_LEAD;
      S_LEAD:  if (tick) state_d = S_TRAIL;
      S_TRAIL: if (tick) state_d = last_bit ? S_HOLD : S_LEAD;
      S_HOLD:  if (tick) state_d = last_q ? S_DESEL : S_WAIT;
      S_WAIT: begin
        if (start_i)    state_d = S_LEAD;
        else if (end_i) state_d = S_DESEL;
      end
      S_DESEL: if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Divider, shift register, per-burst configuration and status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt        <= '0;
      div_q      <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      sel_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      dord_q     <= 1'b0;
      last_q     <= 1'b0;
      samp       <= 1'b0;
      sclk_r     <= 1'b0;
      rx_o       <= '0;
      rx_valid_o <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;

      if (accept || (state_d != state)) cnt <= '0;
      else if (busy_o && (state != S_WAIT)) cnt <= cnt + DIV_W'(1);

      if (accept) begin
        sr      <= tx_i;
        bit_cnt <= '0;
        last_q  <= last_i;
        if (state == S_IDLE) begin
          div_q  <= div_i;
          cpol_q <= cpol_i;
          cpha_q <= cpha_i;
          dord_q <= dord_i;
          sel_q  <= ss_sel_i;
        end
      end

      if (tick) begin
        case (state)
          S_LEAD: begin
            sclk_r <= ~sclk_r;
            if (!cpha_q)              samp <= smp_src;
            else if (bit_cnt != '0)   sr   <= sr_shift;
          end
          S_TRAIL: begin
            sclk_r <= ~sclk_r;
            if (!cpha_q) sr   <= sr_shift;
            else         samp <= smp_src;
            if (!last_bit) bit_cnt <= bit_cnt + BW'(1);
          end
          S_HOLD: begin
            rx_valid_o <= 1'b1;
            rx_o       <= cpha_q ? sr_shift : sr;
            if (cpha_q) sr <= sr_shift;
          end
          default: ;
        endcase
      end

      if ((state == S_HOLD) && tick) irq_o <= 1'b1;
      else if (ack_i)                irq_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_master_gen.sv
// Self-checking bench for spi_master_gen: vector table, burst/corner sequences, random words.
module tb_spi_master_gen;

  localparam int unsigned DW  = 8;
  localparam int unsigned NS  = 4;
  localparam int unsigned DVW = 8;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [DVW-1:0] div_i;
  logic           cpol_i, cpha_i, dord_i;
  logic [1:0]     ss_sel_i;
  logic           start_i, last_i, end_i, ack_i;
  logic [DW-1:0]  tx_i, rx_o;
  logic           rx_valid_o, ready_o, busy_o, irq_o;
  logic           sclk_o, mosi_o, mosi_en_o, miso;
  logic [NS-1:0]  ss_n_o;
  logic           loop = 1'b0;

  spi_master_gen #(.DATA_W(DW), .N_SS(NS), .DIV_W(DVW)) dut (
    .clk_i(clk), .rst_i(rst_i), .div_i(div_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
    .dord_i(dord_i), .ss_sel_i(ss_sel_i), .start_i(start_i), .last_i(last_i),
    .end_i(end_i), .tx_i(tx_i), .rx_o(rx_o), .rx_valid_o(rx_valid_o),
    .ready_o(ready_o), .busy_o(busy_o), .irq_o(irq_o), .ack_i(ack_i),
    .sclk_o(sclk_o), .mosi_o(mosi_o), .mosi_en_o(mosi_en_o), .miso_i(miso),
`ifdef SPI_MASTER_GEN_LOOPBACK_EN
    .loop_i(loop),
`endif
    .ss_n_o(ss_n_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural SPI slave: shifts cur_m out and captures mosi bits by SCK edge count.
  int         ecnt = 0;
  logic       sclk_prev = 1'b0;
  logic [7:0] cur_m = 8'h00;
  logic [7:0] cap = 8'h00;
  logic       cur_cpha = 1'b0;
  logic       cur_dord = 1'b0;

  always @(sclk_o or rx_valid_o or mosi_en_o or rst_i or cur_m or cur_dord or cur_cpha) begin
    int idx;
    if (rst_i || rx_valid_o || !mosi_en_o) ecnt = 0;
    else if (sclk_o !== sclk_prev) begin
      ecnt++;
      if (((ecnt % 2) == 1) == !cur_cpha) begin
        idx = (ecnt - 1) / 2;
        if (idx < 8) cap[3'(cur_dord ? idx : 7 - idx)] = mosi_o;
      end
    end
    sclk_prev = sclk_o;
    idx = cur_cpha ? ((ecnt == 0) ? 0 : (ecnt - 1) / 2) : ecnt / 2;
    if (idx > 7) idx = 7;
    miso = cur_m[3'(cur_dord ? idx : 7 - idx)];
  end

  // Runs one word starting at a negedge; returns at the rx_valid cycle (burst) or at IDLE (last).
  task automatic run_word(input string nm, input logic [7:0] tx, input logic [7:0] m,
                          input logic [7:0] exp_rx, input logic [7:0] dv, input logic cp,
                          input logic ch, input logic dr, input logic [1:0] sel, input logic lst,
                          input int exp_lat, input int poke, input logic ack_hold);
    int   k_rx, k_e1;
    logic ss_ok;
    logic [3:0] exp_ss;
    exp_ss = 4'hF & ~(4'h1 << sel);
    tx_i = tx; div_i = dv; cpol_i = cp; cpha_i = ch; dord_i = dr; ss_sel_i = sel;
    last_i = lst; start_i = 1'b1; end_i = 1'b0; ack_i = ack_hold;
    cur_m = m; cur_cpha = ch; cur_dord = dr;
    k_rx = 0; k_e1 = 0; ss_ok = 1'b1;
    for (int k = 1; k <= exp_lat + 20 && k_rx == 0; k++) begin
      @(negedge clk);
      start_i = (k == poke);
      if (k_e1 == 0 && sclk_o !== cp) k_e1 = k;
      if (rx_valid_o) k_rx = k;
      else if (ss_n_o !== exp_ss) ss_ok = 1'b0;
    end
    start_i = 1'b0;
    ack_i = 1'b0;
    chk({nm, " first_edge_cycle"}, k_e1, 32'(1 + int'(dv) + 1));
    chk({nm, " rx_valid_cycle"}, k_rx, exp_lat);
    chk({nm, " ss_n_during_word"}, ss_ok, 1);
    chk({nm, " rx"}, rx_o, exp_rx);
    chk({nm, " slave_got_mosi"}, cap, tx);
    chk({nm, " irq_set"}, irq_o, 1);
    if (lst) begin
      repeat (int'(dv)) @(negedge clk);
      chk({nm, " ready_in_desel"}, ready_o, 0);
      chk({nm, " ss_n_in_desel"}, ss_n_o, 4'hF);
      @(negedge clk);
      chk({nm, " ready_after"}, ready_o, 1);
      chk({nm, " busy_after"}, busy_o, 0);
      chk({nm, " rx_valid_pulse"}, rx_valid_o, 0);
      chk({nm, " sclk_idle"}, sclk_o, cp);
    end else begin
      chk({nm, " ready_wait_next"}, ready_o, 1);
      chk({nm, " ss_n_wait_next"}, ss_n_o, exp_ss);
    end
  endtask

  typedef struct {
    logic [7:0] dv;
    logic       cpol, cpha, dord;
    logic [7:0] tx, m, exp_rx;
    int         lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int busy_seen;
    int blen;
    logic [7:0] rdv, rtx, rm;
    logic rcp, rch, rdr, rack;
    logic [1:0] rsel;

    tbl[0] = '{8'd1, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'h3C, 35};
    tbl[1] = '{8'd1, 1'b0, 1'b1, 1'b1, 8'h81, 8'hA5, 8'hA5, 35};
    tbl[2] = '{8'd1, 1'b1, 1'b0, 1'b1, 8'h81, 8'h81, 8'h81, 35};
    tbl[3] = '{8'd1, 1'b1, 1'b1, 1'b1, 8'h81, 8'h81, 8'h81, 35};
    tbl[4] = '{8'd0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hC3, 8'hC3, 18};
    tbl[5] = '{8'd2, 1'b1, 1'b1, 1'b0, 8'h0F, 8'hF0, 8'hF0, 52};

    rst_i = 1'b1; div_i = '0; cpol_i = 1'b0; cpha_i = 1'b0; dord_i = 1'b0; ss_sel_i = '0;
    start_i = 1'b0; last_i = 1'b0; end_i = 1'b0; ack_i = 1'b0; tx_i = '0;
    repeat (2) @(negedge clk);
    chk("reset ss_n", ss_n_o, 4'hF);
    chk("reset sclk_cpol0", sclk_o, 0);
    chk("reset mosi", mosi_o, 0);
    chk("reset mosi_en", mosi_en_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset ready", ready_o, 1);
    chk("reset irq", irq_o, 0);
    chk("reset rx_valid", rx_valid_o, 0);
    chk("reset rx", rx_o, 0);
    cpol_i = 1'b1;
    #1 chk("reset sclk_cpol1", sclk_o, 1);
    @(negedge clk);
    cpol_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_word($sformatf("vec%0d", i), tbl[i].tx, tbl[i].m, tbl[i].exp_rx, tbl[i].dv,
               tbl[i].cpol, tbl[i].cpha, tbl[i].dord, 2'd0, 1'b1, tbl[i].lat, 0, 1'b0);
      ack_i = 1'b1;
      @(negedge clk);
      ack_i = 1'b0;
      chk($sformatf("vec%0d irq_ack", i), irq_o, 0);
    end

    // Three-word burst on slave 2; ack held during word 2 collides with its irq set.
    run_word("burst_w1", 8'h12, 8'hE1, 8'hE1, 8'd1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 35, 0, 1'b0);
    run_word("burst_w2", 8'h34, 8'hD2, 8'hD2, 8'd1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 35, 0, 1'b1);
    run_word("burst_w3", 8'h56, 8'hC3, 8'hC3, 8'd1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 35, 0, 1'b0);
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;

    // Open burst closed with end_i from WAIT_NEXT.
    run_word("open_burst", 8'h9C, 8'h63, 8'h63, 8'd1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 35, 0, 1'b0);
    end_i = 1'b1;
    @(negedge clk);
    end_i = 1'b0;
    chk("end desel ss_n", ss_n_o, 4'hF);
    chk("end desel busy", busy_o, 1);
    chk("end desel ready", ready_o, 0);
    chk("end desel mosi_en", mosi_en_o, 0);
    repeat (2) @(negedge clk);
    chk("end idle busy", busy_o, 0);
    chk("end idle ready", ready_o, 1);

    // start_i pulsed during TRAIL must not queue a second word.
    run_word("start_in_trail", 8'hC5, 8'h5C, 8'h5C, 8'd2, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 52, 5, 1'b0);
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy_o || rx_valid_o) busy_seen++;
    end
    chk("start_in_trail no_extra_word", busy_seen, 0);

    // Asynchronous reset in the middle of TRAIL.
    tx_i = 8'hF3; div_i = 8'd3; cpol_i = 1'b1; cpha_i = 1'b0; dord_i = 1'b0;
    ss_sel_i = 2'd0; last_i = 1'b1; start_i = 1'b1; cur_cpha = 1'b0; cur_dord = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst pre sclk_in_trail", sclk_o, 0);
    rst_i = 1'b1;
    #1;
    chk("rst mid ss_n", ss_n_o, 4'hF);
    chk("rst mid sclk", sclk_o, 1);
    chk("rst mid mosi", mosi_o, 0);
    chk("rst mid mosi_en", mosi_en_o, 0);
    chk("rst mid busy", busy_o, 0);
    chk("rst mid ready", ready_o, 1);
    chk("rst mid irq", irq_o, 0);
    chk("rst mid rx_valid", rx_valid_o, 0);
    chk("rst mid rx", rx_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    run_word("after_rst", 8'h6B, 8'hB6, 8'hB6, 8'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 35, 0, 1'b0);

    // Random words and short bursts against the slave model and timing formula.
    for (int n = 0; n < 20; n++) begin
      rdv  = 8'($urandom_range(3, 0));
      rcp  = 1'($urandom); rch = 1'($urandom); rdr = 1'($urandom);
      rsel = 2'($urandom);
      blen = int'($urandom_range(3, 1));
      for (int w = 0; w < blen; w++) begin
        rtx  = 8'($urandom);
        rm   = 8'($urandom);
        rack = 1'($urandom);
        run_word($sformatf("rand%0d_w%0d", n, w), rtx, rm, rm, rdv, rcp, rch, rdr, rsel,
                 (w == blen - 1), 1 + 17 * (int'(rdv) + 1), 0, rack);
      end
      ack_i = 1'b1;
      @(negedge clk);
      ack_i = 1'b0;
    end

`ifdef SPI_MASTER_GEN_LOOPBACK_EN
    loop = 1'b1;
    run_word("loop_m0", 8'h5A, 8'hC3, 8'h5A, 8'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 35, 0, 1'b0);
    run_word("loop_m3", 8'h5A, 8'h00, 8'h5A, 8'd1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 35, 0, 1'b0);
    loop = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_gen.md
# spi_master_gen

Parametrised SPI master with built-in SCK divider, N chip selects driven by the block, and multi-word bursts that keep the slave selected between words. It sits between a register/CPU front-end and the SPI pads. Mode (CPOL/CPHA/DORD) and divider are latched per burst, so the front-end can change them freely while a transfer runs. It replaces the need for an external enable generator and SS logic.

## Interface
- DATA_W, 8: word width in bits, ≥2; bit counter width is $clog2(DATA_W).
- N_SS, 1: number of active-low slave selects, ≥1.
- DIV_W, 8: divider width; half SCK period D = div_i+1 clk cycles.
- SS_W, (N_SS>1 ? $clog2(N_SS) : 1): width of ss_sel_i; derived, not overridden.

- clk_i  in  1  system clock; the block's only clock.
- rst_i  in  1  reset, asynchronous, active-high.
- div_i  in  DIV_W  SCK half period minus one; latched on burst start.
- cpol_i, cpha_i, dord_i  in  1 each  SCK idle level, 1=trailing-edge sample, 1=LSB first; latched on burst start.
- ss_sel_i  in  SS_W  slave index; latched on burst start.
- start_i  in  1  load tx_i and send one word; accepted only while ready_o=1.
- last_i  in  1  qualifies start_i: this word ends the burst.
- end_i  in  1  close an open burst while in WAIT_NEXT.
- tx_i  in  DATA_W  word to transmit.
- rx_o  out  DATA_W  last received word.
- rx_valid_o  out  1  one-cycle pulse when rx_o is updated.
- ready_o  out  1  start_i is accepted this cycle.
- busy_o  out  1  state ≠ IDLE.
- irq_o  out  1  sticky word-done flag.
- ack_i  in  1  clears irq_o.
- sclk_o, mosi_o, mosi_en_o  out  1 each; miso_i  in  1.
- ss_n_o  out  N_SS  active-low slave selects.

## Operation
- States: IDLE, LEAD, TRAIL, HOLD, WAIT_NEXT, DESEL. A tick fires on the D-th cycle in the current half period. The divider counter clears on every state change and on any accepted start.
- IDLE: ready_o=1; on start_i, latch div, mode, ss_sel, last_i and tx_i → LEAD, bit_cnt=0.
- LEAD, on tick: leading SCK edge → TRAIL; cpha=0 samples miso.
- TRAIL, on tick: trailing SCK edge. cpha=1 samples miso. If bit_cnt=DATA_W-1 → HOLD, otherwise bit_cnt+1 → LEAD.
- Shift register:
  - cpha=0 shifts on each trailing edge.
  - cpha=1 shifts on leading edges of bits 1..DATA_W-1 and at HOLD exit.
  - dord=1 shifts right, inserting the sample at the MSB. dord=0 shifts left, inserting at the LSB.
  - mosi_o is reg[0] when dord=1, otherwise reg[DATA_W-1].
- HOLD, on tick: rx_o←reg, pulse rx_valid_o, set irq_o. If the latched last flag is 1 → DESEL, otherwise → WAIT_NEXT.
- WAIT_NEXT: ss held low, SCK idle, ready_o=1.
  - start_i loads tx_i and last_i → LEAD; ss_sel_i and mode inputs are ignored.
  - end_i alone → DESEL.
  - start_i and end_i together: start wins.
- DESEL: ss_n_o all high for one half period; on tick → IDLE.
- ss_n_o[sel] is low in LEAD, TRAIL, HOLD and WAIT_NEXT; all other bits stay high. A latched ss_sel ≥ N_SS selects nothing.
- sclk_o = sclk_r ^ cpol. Use latched cpol when busy, cpol_i in IDLE.
- mosi_en_o = busy_o and state ≠ DESEL.
- irq_o: ack_i clears it; a set in the same cycle wins.
- start_i in LEAD, TRAIL, HOLD or DESEL is ignored and not queued.

## Timing
- Reset values: ss_n_o all 1, sclk_o=cpol_i, mosi_o=0, mosi_en_o=0, busy_o=0, ready_o=1, irq_o=0, rx_valid_o=0, rx_o=0.
- Asserting rst_i mid-transfer forces these values immediately with no SCK glitch beyond the cpol level.
- Start accepted in cycle t → LEAD entered, ss low and busy high at t+1.
- SCK edge k (1..2·DATA_W) becomes visible at t+1+k·D.
- rx_valid_o is high in cycle t+1+(2·DATA_W+1)·D.
- A single word ends with ss high at the rx_valid cycle + D; ready_o returns 1 in that same cycle.
- In a burst, a start in WAIT_NEXT at cycle u gives the same formulas with t=u. Minimum gap between words is one clk cycle.

## Configuration
- SPI_MASTER_GEN_LOOPBACK_EN defined: adds input loop_i (1 bit). When loop_i=1, the sampled data is mosi_o instead of miso_i, and pads still toggle.
- Macro undefined: the port is absent and sampling always uses miso_i.

## Test plan
- DATA_W=8, div_i=1, mode 0, dord=0, tx=0xA5, miso driven with 0x3C, last=1, start at t → first SCK edge at t+3, mosi bits 1,0,1,0,0,1,0,1, rx_o=0x3C with rx_valid at t+35, ss_n high at t+37.
- Modes 1–3 with dord=1, tx=0x81, slave model echoing the previous byte → rx matches the model per mode, sclk idle level = cpol.
- N_SS=4, ss_sel=2, 3-word burst (last on word 3) → ss_n_o=4'b1011 continuously across words, three rx_valid pulses, irq set each word; ack in the same cycle as a set leaves irq=1.
- Burst with last=0, then end_i in WAIT_NEXT → DESEL then IDLE. start_i during TRAIL → ignored, no extra word.
- rst_i asserted mid-TRAIL → all outputs at reset values before the next clk edge; a new start afterwards runs normally.
- With SPI_MASTER_GEN_LOOPBACK_EN and loop_i=1, tx=0x5A → rx_o=0x5A irrespective of miso_i.
